// File: rtl/muldiv_unit.sv
// Execute-stage MULT/MULTU/DIV/DIVU unit: registered multiply (done 2 cycles after start), radix-2 restoring divide (done 34 cycles after start).
// Holds the front of the pipeline via stall while busy; flush aborts at the next edge without touching hi/lo.
module muldiv_unit #(
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CW = $clog2(DIV_ITERS + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t         r_state;
  state_t         w_next;
  logic           r_signed;
  logic           r_div_first;
  logic [31:0]    r_a;
  logic [31:0]    r_b;
  logic [31:0]    r_rem;
  logic [31:0]    r_quo;
  logic [31:0]    r_dvs;
  logic [31:0]    r_hi;
  logic [31:0]    r_lo;
  logic [CW-1:0]  r_cnt;

  logic           w_accept;
  logic [63:0]    w_mul_a;
  logic [63:0]    w_mul_b;
  logic [63:0]    w_prod;
  logic [31:0]    w_abs_a;
  logic [31:0]    w_abs_b;
  logic [32:0]    w_rem_sh;
  logic [32:0]    w_trial;
  logic [31:0]    w_rem_nx;
  logic [31:0]    w_quo_nx;
  logic [31:0]    w_q_fix;
  logic [31:0]    w_r_fix;
  logic           w_last;
  logic           w_div0;

  assign w_accept = start && !flush;

  // Sign-extending only for MULT lets one 64-bit multiply serve both flavours.
  assign w_mul_a = {{32{r_signed & r_a[31]}}, r_a};
  assign w_mul_b = {{32{r_signed & r_b[31]}}, r_b};
  assign w_prod  = w_mul_a * w_mul_b;

  assign w_abs_a = (r_signed && r_a[31]) ? -r_a : r_a;
  assign w_abs_b = (r_signed && r_b[31]) ? -r_b : r_b;

  // Bit 32 of the trial difference is its sign: set means the divisor did not fit.
  assign w_rem_sh = {r_rem, r_quo[31]};
  assign w_trial  = w_rem_sh - {1'b0, r_dvs};
  assign w_rem_nx = w_trial[32] ? w_rem_sh[31:0] : w_trial[31:0];
  assign w_quo_nx = {r_quo[30:0], ~w_trial[32]};

  assign w_q_fix = (r_signed && (r_a[31] ^ r_b[31])) ? -w_quo_nx : w_quo_nx;
  assign w_r_fix = (r_signed && r_a[31]) ? -w_rem_nx : w_rem_nx;
  assign w_last  = (r_cnt == CW'(DIV_ITERS - 1));
  assign w_div0  = (r_b == 32'd0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    stall  = 1'b0;
    done   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = op[1] ? S_DIV : S_MUL;
          stall  = 1'b1;
        end
      end
      S_MUL: begin
        w_next = S_DONE;
        stall  = 1'b1;
      end
      S_DIV: begin
        if (!r_div_first && w_last) begin
          w_next = S_DONE;
        end
        stall = 1'b1;
      end
      S_DONE: begin
        w_next = S_IDLE;
        done   = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
    if (flush) begin
      w_next = S_IDLE;
      stall  = 1'b0;
      done   = 1'b0;
    end
    if (!resetn) begin
      stall = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_signed    <= 1'b0;
      r_div_first <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvs       <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_cnt       <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_signed    <= ~op[0];
            r_a         <= a;
            r_b         <= b;
            r_div_first <= 1'b1;
          end
        end
        S_MUL: begin
          if (!flush) begin
            r_hi <= w_prod[63:32];
            r_lo <= w_prod[31:0];
          end
        end
        S_DIV: begin
          if (r_div_first) begin
            r_rem       <= '0;
            r_quo       <= w_abs_a;
            r_dvs       <= w_abs_b;
            r_cnt       <= '0;
            r_div_first <= 1'b0;
          end else begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            r_cnt <= r_cnt + CW'(1);
            if (w_last && !flush) begin
              r_hi <= w_div0 ? r_a : w_r_fix;
              r_lo <= w_div0 ? 32'hFFFF_FFFF : w_q_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Execute-stage multiply/divide unit for MULT, MULTU, DIV and DIVU. It sits in the execute stage, directly upstream of the memory stage. It computes the HI/LO pair that the execute stage places in its hi/lo fields toward the memory stage. While an operation is in flight it stalls the front of the pipeline. Multiplies are single-cycle registered; divides use an iterative radix-2 restoring algorithm.

Parameters:
DIV_ITERS, 32, number of quotient bits produced, one per cycle (equals the operand width).

Ports:
clk  input  1  clock
resetn  input  1  asynchronous active-low reset
start  input  1  execute stage holds a muldiv instruction (level; held until done)
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
a  input  32  rs operand
b  input  32  rt operand
flush  input  1  synchronous abort of the current operation
stall  output  1  hold fetch/decode/execute this cycle
done  output  1  hi/lo valid this cycle; instruction advances at the end of it
hi  output  32  MULT: product[63:32]; DIV: remainder
lo  output  32  MULT: product[31:0]; DIV: quotient

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, resetn.
- Reset values: state=IDLE, hi=0, lo=0, done=0, stall=0, iteration counter=0. Reset mid-operation discards the operation.
- States:
  - IDLE: if start && !flush, latch op, a and b, then go to MUL (op[1]=0) or DIV (op[1]=1).
  - MUL: compute the 64-bit product; it is signed for MULT and unsigned for MULTU. Register it into hi/lo, then go to DONE.
  - DIV: first cycle takes the magnitudes (|a|, |b| for DIV; raw values for DIVU) and clears the remainder register; counter=0. Each following cycle:
    - shift {rem, quo} left by 1;
    - trial = rem - divisor;
    - if trial is non-negative, rem=trial and quo[0]=1.
  - Completion: after DIV_ITERS iterations, apply sign fix-up (signed only) and write hi/lo, then go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE. start is ignored in DONE because it still belongs to the retiring instruction.
- Sign rules (DIV): quotient negated if a[31]^b[31]; remainder takes the sign of a. 0x80000000 / -1 gives lo=0x80000000, hi=0.
- Divide by zero: same latency; lo=32'hFFFF_FFFF, hi=a (for DIV, hi=a as signed, unmodified).
- stall = (state==IDLE && start && !flush) || state==MUL || state==DIV. stall is 0 in DONE.
- Latency, counted from the first cycle start is seen in IDLE:
  - MULT/MULTU: stall for 2 cycles; done in cycle 2.
  - DIV/DIVU: stall for 1 + 1 + DIV_ITERS = 34 cycles; done in cycle 34.
- hi/lo hold their last value until the next completion. They change only on entry to DONE.
- flush:
  - In any state, returns to IDLE on the next edge; hi/lo are not updated.
  - done is not asserted.
  - stall is 0 in the flush cycle.
  - flush has priority over completion in the same cycle.
- Back-to-back operations: the next start is sampled in the IDLE cycle after DONE. There is no one-cycle overlap.
- All arithmetic is unsigned 33-bit for the trial subtraction. Products use a 64-bit signed/unsigned multiply selected by op[0].

Test Plan:
- MULTU a=FFFFFFFF b=FFFFFFFF: expect stall high for 2 cycles, then done with hi=FFFFFFFE and lo=00000001.
- MULT a=FFFFFFFE (-2) b=00000003: expect hi=FFFFFFFF, lo=FFFFFFFA; a back-to-back MULTU 5*7 then yields hi=0, lo=35 two cycles after the following IDLE.
- DIV a=FFFFFFF9 (-7) b=2: expect stall high for 34 cycles, then done with lo=FFFFFFFD and hi=FFFFFFFF.
- DIVU a=100 b=7: expect lo=14, hi=2. DIV 80000000/FFFFFFFF: expect lo=80000000, hi=0.
- DIVU a=1234 b=0: expect same latency, lo=FFFFFFFF, hi=1234. Prior hi/lo must be held unchanged during the busy cycles.
- Flush at DIV cycle 10: expect IDLE next cycle, stall=0, done never asserted, hi/lo unchanged. Drop resetn mid-divide: expect outputs 0 immediately (asynchronous), IDLE after release.
